// File: rtl/seg_digit_decoder.sv
// Receive side of a 7-segment display bus: synchronizes the active-low segment lines, filters them
// for stability and recovers the displayed BCD digit, with change strobe/counter and step checker.
module seg_digit_decoder #(
  parameter int unsigned STABLE_CYCLES = 20000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       blank,
  output logic       err,
  output logic       digit_strobe,
  output logic [7:0] change_count,
  output logic       step_err
);

  localparam logic [6:0]       PatBlank  = 7'b1111111;
  localparam logic [CNT_W-1:0] StableMax = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] StableM1  = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       sync1_q, sync2_q, cand_q, acc_pat_q;
  logic [6:0]       cand_d, acc_pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       digit_q, digit_d, last_q, last_d;
  logic             valid_q, valid_d, blank_q, blank_d, err_q, err_d;
  logic             strobe_q, strobe_d, step_err_q, step_err_d, have_prev_q, have_prev_d;
  logic [7:0]       count_q, count_d;

  logic             accept;
  logic             dec_ok;
  logic [3:0]       dec_val;
  logic [3:0]       last_next;

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    unique case (sync2_q)
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // cnt reaches StableM1 on the last edge before saturation, so accept fires once per run.
  assign accept    = (sync2_q == cand_q) && (cnt_q == StableM1);
  assign last_next = (last_q == 4'd9) ? 4'd0 : last_q + 4'd1;

  always_comb begin
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    acc_pat_d   = acc_pat_q;
    digit_d     = digit_q;
    valid_d     = valid_q;
    blank_d     = blank_q;
    err_d       = err_q;
    strobe_d    = 1'b0;
    count_d     = count_q;
    step_err_d  = step_err_q;
    have_prev_d = have_prev_q;
    last_d      = last_q;

    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CNT_W'(1);
    end else if (cnt_q < StableMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (accept) begin
      acc_pat_d = sync2_q;
      if (dec_ok) begin
        digit_d = dec_val;
        valid_d = 1'b1;
        blank_d = 1'b0;
        err_d   = 1'b0;
      end else if (sync2_q == PatBlank) begin
        valid_d = 1'b0;
        blank_d = 1'b1;
        err_d   = 1'b0;
      end else begin
        valid_d = 1'b0;
        blank_d = 1'b0;
        err_d   = 1'b1;
      end

      if (sync2_q != acc_pat_q) begin
        strobe_d = 1'b1;
        count_d  = count_q + 8'd1;
        if (dec_ok) begin
          if (have_prev_q && (dec_val != last_next)) step_err_d = 1'b1;
          last_d      = dec_val;
          have_prev_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= PatBlank;
      sync2_q     <= PatBlank;
      cand_q      <= PatBlank;
      acc_pat_q   <= PatBlank;
      cnt_q       <= StableMax;
      digit_q     <= 4'd0;
      valid_q     <= 1'b0;
      blank_q     <= 1'b1;
      err_q       <= 1'b0;
      strobe_q    <= 1'b0;
      count_q     <= 8'd0;
      step_err_q  <= 1'b0;
      have_prev_q <= 1'b0;
      last_q      <= 4'd0;
    end else begin
      sync1_q     <= seg_in;
      sync2_q     <= sync1_q;
      cand_q      <= cand_d;
      acc_pat_q   <= acc_pat_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      valid_q     <= valid_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
      strobe_q    <= strobe_d;
      count_q     <= count_d;
      step_err_q  <= step_err_d;
      have_prev_q <= have_prev_d;
      last_q      <= last_d;
    end
  end

  assign digit_out    = digit_q;
  assign digit_valid  = valid_q;
  assign blank        = blank_q;
  assign err          = err_q;
  assign digit_strobe = strobe_q;
  assign change_count = count_q;
  assign step_err     = step_err_q;

endmodule

// File: tb/tb_seg_digit_decoder.sv
// Randomized bench for seg_digit_decoder: a run-length/lookup-table model predicts every output
// after every clock edge.
module tb_seg_digit_decoder;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic [3:0] digit_out;
  logic       digit_valid, blank, err, digit_strobe, step_err;
  logic [7:0] change_count;

  seg_digit_decoder #(
    .STABLE_CYCLES(S),
    .CNT_W        (16)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .blank       (blank),
    .err         (err),
    .digit_strobe(digit_strobe),
    .change_count(change_count),
    .step_err    (step_err)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model state: what the display "looks like" at the filter input and what has been accepted.
  logic [6:0] hist [$];
  logic [6:0] m_cur, m_acc;
  int         m_run;
  int         m_digit, m_last;
  bit         m_valid, m_blank, m_err, m_strobe, m_step_err, m_have_prev;
  int         m_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist = '{7'h7f, 7'h7f};
    m_cur = 7'h7f; m_acc = 7'h7f; m_run = S;
    m_digit = 0; m_last = 0; m_valid = 0; m_blank = 1; m_err = 0;
    m_strobe = 0; m_step_err = 0; m_have_prev = 0; m_count = 0;
  endtask

  // The pattern reaching the filter lags the pin by two edges; a run of S identical filter
  // samples that starts with a fresh pattern is accepted on its S-th sample.
  task automatic model_edge(input logic [6:0] pin);
    logic [6:0] v;
    int d;
    bit acc;
    v = hist.pop_front();
    hist.push_back(pin);
    acc = 0;
    m_strobe = 0;
    if (v != m_cur) begin
      m_cur = v;
      m_run = 1;
    end else if (m_run < S) begin
      m_run++;
      acc = (m_run == S);
    end
    if (acc) begin
      d = lookup(v);
      if (v != m_acc) begin
        m_strobe = 1;
        m_count = (m_count + 1) % 256;
        if (d >= 0) begin
          if (m_have_prev && d != (m_last + 1) % 10) m_step_err = 1;
          m_last = d;
          m_have_prev = 1;
        end
      end
      m_acc = v;
      m_valid = (d >= 0);
      m_blank = (d < 0) && (v == 7'h7f);
      m_err = (d < 0) && (v != 7'h7f);
      if (d >= 0) m_digit = d;
    end
  endtask

  task automatic check_all();
    check_eq("digit_out", 32'(digit_out), 32'(m_digit));
    check_eq("digit_valid", 32'(digit_valid), 32'(m_valid));
    check_eq("blank", 32'(blank), 32'(m_blank));
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("digit_strobe", 32'(digit_strobe), 32'(m_strobe));
    check_eq("change_count", 32'(change_count), 32'(m_count));
    check_eq("step_err", 32'(step_err), 32'(m_step_err));
  endtask

  task automatic tick(input logic [6:0] p);
    seg_in = p;
    @(posedge clk);
    model_edge(p);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [6:0] p, input int cycles);
    for (int i = 0; i < cycles; i++) tick(p);
  endtask

  // Asynchronous reset mid-cycle: outputs must drop to the blank state before any clock edge.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  function automatic logic [6:0] rand_pat();
    int k;
    k = $urandom_range(0, 13);
    if (k < 10) return seg_tab[k];
    if (k < 12) return 7'h7f;
    return 7'($urandom);
  endfunction

  initial begin
    int dg;
    rst = 1'b1;
    seg_in = 7'h7f;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    hold(7'h7f, 20);
    // First digit: latency, then a short glitch inside a stable run.
    hold(seg_tab[1], 8);
    hold(seg_tab[2], 3);
    hold(seg_tab[1], 8);

    // Random patterns with random hold lengths, many shorter than the filter window.
    for (int i = 0; i < 350; i++) hold(rand_pat(), $urandom_range(1, 8));

    // Legal counting sequence with blanks inserted, long enough to wrap change_count.
    pulse_reset();
    dg = $urandom_range(0, 9);
    for (int i = 0; i < 290; i++) begin
      if ($urandom_range(0, 4) == 0) hold(7'h7f, $urandom_range(S, 7));
      hold(seg_tab[dg], $urandom_range(S, 7));
      dg = (dg + 1) % 10;
    end

    // Step violation, sticky through later legal steps, then an error pattern.
    pulse_reset();
    hold(seg_tab[3], 8);
    hold(seg_tab[5], 8);
    hold(seg_tab[6], 8);
    hold(7'b1110000, 8);

    // Reset during the third stable cycle of a new digit, then a fresh acceptance.
    hold(seg_tab[7], 2 + 3);
    pulse_reset();
    hold(seg_tab[7], 10);
    for (int i = 0; i < 40; i++) begin
      hold(rand_pat(), $urandom_range(2, 9));
      if ($urandom_range(0, 9) == 0) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
